// File: rtl/serial_adder.sv
// serial_adder: digit-serial add/subtract unit with valid/ready handshakes.
// Processes DIGIT bits per clock through a DIGIT-wide full-adder ripple, with
// the inter-digit carry held in a register. Operands are accepted in IDLE,
// processed over NDIG = WIDTH/DIGIT RUN cycles, and held in DONE until taken.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (A, B, Cin, Sub)
//   A, B                 WIDTH-bit operands
//   Cin                  carry-in (add) / borrow-in (sub)
//   Sub                  0: A+B+Cin, 1: A-B-Cin
//   out_valid/out_ready  result handshake (Sum, Cout, Ovf)
//   Sum                  result modulo 2^WIDTH
//   Cout                 carry-out (add) / borrow-out (sub)
//   Ovf                  two's-complement signed overflow
module serial_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic             sub_q;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] dsum_c;
  logic [DIGIT:0]   cc_c;
  logic [WIDTH-1:0] sum_next_c;

  // One digit of full-adder stages; cc_c[i] is the carry into bit i.
  assign cc_c[0] = carry;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign dsum_c[i]  = a_sh[i] ^ b_sh[i] ^ cc_c[i];
    assign cc_c[i+1]  = (a_sh[i] & b_sh[i]) | (cc_c[i] & (a_sh[i] ^ b_sh[i]));
  end

  // New digit enters Sum from the MSB end; earlier digits move toward the LSB.
  assign sum_next_c = (Sum >> DIGIT) | (WIDTH'(dsum_c) << (WIDTH - DIGIT));

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Sum       <= '0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
      sub_q     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction as A + ~B + ~Cin.
            a_sh     <= A;
            b_sh     <= Sub ? ~B : B;
            carry    <= Sub ? ~Cin : Cin;
            sub_q    <= Sub;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          Sum   <= sum_next_c;
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          carry <= cc_c[DIGIT];
          if (cnt == CW'(NDIG - 1)) begin
            // Last digit: its top stage is the word MSB.
            cnt       <= '0;
            Cout      <= sub_q ? ~cc_c[DIGIT] : cc_c[DIGIT];
            Ovf       <= cc_c[DIGIT-1] ^ cc_c[DIGIT];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder. Four instances with
// DIGIT = 1, 2, 4, 16 (WIDTH = 16); the DIGIT=4 instance carries the directed
// scenarios, all four run the randomized back-to-back sweep concurrently.
module tb_serial_adder;

  localparam int unsigned W    = 16;
  localparam int          NI   = 4;
  localparam int          MAIN = 2;
  localparam int          NOPS = 2000;

  function automatic int unsigned dig_of(input int k);
    case (k)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      default: return 16;
    endcase
  endfunction

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int unsigned  acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         iv  [NI];
  logic         ir  [NI];
  logic         ov  [NI];
  logic         orr [NI];
  logic         cin [NI];
  logic         sb  [NI];
  logic         co  [NI];
  logic         of  [NI];
  logic [W-1:0] a   [NI];
  logic [W-1:0] b   [NI];
  logic [W-1:0] s   [NI];

  int          nassert = 0;
  int          nfail   = 0;
  int unsigned cyc     = 0;
  exp_t        dq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    serial_adder #(.WIDTH(W), .DIGIT(dig_of(g))) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv[g]), .in_ready(ir[g]),
      .A(a[g]), .B(b[g]), .Cin(cin[g]), .Sub(sb[g]),
      .out_valid(ov[g]), .out_ready(orr[g]),
      .Sum(s[g]), .Cout(co[g]), .Ovf(of[g])
    );
  end

  // Reference: arithmetic on plain integers, overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic sub, input int unsigned acc);
    exp_t       e;
    logic [W:0] r;
    if (!sub) begin
      r      = {1'b0, x} + {1'b0, y} + (W+1)'(c);
      e.sum  = r[W-1:0];
      e.cout = r[W];
      e.ovf  = (x[W-1] == y[W-1]) && (e.sum[W-1] != x[W-1]);
    end else begin
      r      = {1'b0, x} - {1'b0, y} - (W+1)'(c);
      e.sum  = r[W-1:0];
      e.cout = ({1'b0, x} < ({1'b0, y} + (W+1)'(c)));
      e.ovf  = (x[W-1] != y[W-1]) && (e.sum[W-1] != x[W-1]);
    end
    e.acc = acc;
    return e;
  endfunction

  // Present operands to the main instance; returns at the negedge after acceptance.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input logic sub, output bit ok);
    int t;
    @(negedge clk);
    a[MAIN] = x; b[MAIN] = y; cin[MAIN] = c; sb[MAIN] = sub; iv[MAIN] = 1'b1;
    t = 0;
    while (!ir[MAIN] && t < 50) begin
      @(negedge clk);
      t++;
    end
    ok = ir[MAIN];
    if (ok) dq.push_back(model(x, y, c, sub, cyc + 1));
    @(negedge clk);
    iv[MAIN] = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int t;
    t = 0;
    while (!ov[MAIN] && t < 100) begin
      @(negedge clk);
      t++;
    end
    ok = ov[MAIN];
  endtask

  // Full directed transaction: observed result, scoreboard entry, latency.
  task automatic one_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic sub,
                        output exp_t got, output exp_t want,
                        output int unsigned lat, output bit ok);
    bit ok1, ok2;
    got  = '{default: '0};
    want = '{default: '0};
    lat  = 0;
    start_op(x, y, c, sub, ok1);
    ok2 = 1'b0;
    if (ok1) wait_done(ok2);
    ok = ok1 && ok2 && (dq.size() > 0);
    if (!ok) return;
    want = dq.pop_front();
    got.sum = s[MAIN]; got.cout = co[MAIN]; got.ovf = of[MAIN];
    lat = cyc - want.acc;
    orr[MAIN] = 1'b1;
    @(negedge clk);
    orr[MAIN] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    for (int k = 0; k < NI; k++) begin
      nassert++;
      if (ir[k] !== 1'b1 || ov[k] !== 1'b0 || s[k] !== '0 || co[k] !== 1'b0 || of[k] !== 1'b0) begin
        nfail++;
        $display("FAIL reset_state inst=%0d got ir=%b ov=%b sum=%h cout=%b ovf=%b want ir=1 ov=0 sum=0000 cout=0 ovf=0",
                 k, ir[k], ov[k], s[k], co[k], of[k]);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    nassert++;
    if (ir[MAIN] !== 1'b1 || ov[MAIN] !== 1'b0) begin
      nfail++;
      $display("FAIL after_reset got ir=%b ov=%b want ir=1 ov=0", ir[MAIN], ov[MAIN]);
    end
  endtask

  task automatic test_add_basic;
    exp_t got, want; int unsigned lat; bit ok;
    one_op(16'h1234, 16'h0FED, 1'b1, 1'b0, got, want, lat, ok);
    nassert++;
    if (!ok) begin
      nfail++; $display("FAIL add_basic_timeout got no result want result");
    end else begin
      nassert++;
      if (got.sum !== 16'h2222 || got.cout !== 1'b0 || got.ovf !== 1'b0) begin
        nfail++;
        $display("FAIL add_basic got sum=%h cout=%b ovf=%b want sum=2222 cout=0 ovf=0", got.sum, got.cout, got.ovf);
      end
      if (got.sum !== want.sum) begin
        nfail++; $display("FAIL add_basic_model got sum=%h want %h", got.sum, want.sum);
      end
      nassert++;
      if (lat !== 4) begin
        nfail++; $display("FAIL add_basic_latency got %0d want 4", lat);
      end
    end
  endtask

  task automatic test_add_edges;
    exp_t got, want; int unsigned lat; bit ok;
    one_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, got, want, lat, ok);
    nassert++;
    if (!ok || got.sum !== 16'h0000 || got.cout !== 1'b1 || got.ovf !== 1'b0) begin
      nfail++;
      $display("FAIL add_wrap ok=%b got sum=%h cout=%b ovf=%b want sum=0000 cout=1 ovf=0", ok, got.sum, got.cout, got.ovf);
    end
    one_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, got, want, lat, ok);
    nassert++;
    if (!ok || got.sum !== want.sum || got.cout !== want.cout || got.ovf !== want.ovf || got.ovf !== 1'b1) begin
      nfail++;
      $display("FAIL add_ovf ok=%b got sum=%h cout=%b ovf=%b want sum=8000 cout=0 ovf=1", ok, got.sum, got.cout, got.ovf);
    end
  endtask

  task automatic test_sub;
    exp_t got, want; int unsigned lat; bit ok;
    one_op(16'h0005, 16'h0007, 1'b0, 1'b1, got, want, lat, ok);
    nassert++;
    if (!ok || got.sum !== 16'hFFFE || got.cout !== 1'b1 || got.ovf !== 1'b0) begin
      nfail++;
      $display("FAIL sub_borrow ok=%b got sum=%h cout=%b ovf=%b want sum=fffe cout=1 ovf=0", ok, got.sum, got.cout, got.ovf);
    end
    one_op(16'h8000, 16'h0001, 1'b0, 1'b1, got, want, lat, ok);
    nassert++;
    if (!ok || got.sum !== 16'h7FFF || got.cout !== 1'b0 || got.ovf !== 1'b1) begin
      nfail++;
      $display("FAIL sub_ovf ok=%b got sum=%h cout=%b ovf=%b want sum=7fff cout=0 ovf=1", ok, got.sum, got.cout, got.ovf);
    end
    one_op(16'h0010, 16'h0003, 1'b1, 1'b1, got, want, lat, ok);
    nassert++;
    if (!ok || got.sum !== want.sum || got.cout !== want.cout || got.ovf !== want.ovf) begin
      nfail++;
      $display("FAIL sub_bin ok=%b got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
               ok, got.sum, got.cout, got.ovf, want.sum, want.cout, want.ovf);
    end
  endtask

  task automatic test_hold;
    exp_t want; bit ok1, ok2;
    start_op(16'h1234, 16'h0FED, 1'b1, 1'b0, ok1);
    ok2 = 1'b0;
    if (ok1) wait_done(ok2);
    nassert++;
    if (!ok1 || !ok2 || dq.size() == 0) begin
      nfail++; $display("FAIL hold_timeout got no result want result");
      return;
    end
    want = dq.pop_front();
    for (int i = 0; i < 10; i++) begin
      nassert++;
      if (s[MAIN] !== want.sum || co[MAIN] !== want.cout || of[MAIN] !== want.ovf ||
          ir[MAIN] !== 1'b0 || ov[MAIN] !== 1'b1) begin
        nfail++;
        $display("FAIL hold_stable cyc=%0d got sum=%h cout=%b ovf=%b ir=%b ov=%b want sum=%h cout=%b ovf=%b ir=0 ov=1",
                 i, s[MAIN], co[MAIN], of[MAIN], ir[MAIN], ov[MAIN], want.sum, want.cout, want.ovf);
      end
      iv[MAIN] = 1'($urandom_range(0, 1));
      a[MAIN]  = W'($urandom);
      b[MAIN]  = W'($urandom);
      @(negedge clk);
    end
    iv[MAIN]  = 1'b0;
    orr[MAIN] = 1'b1;
    @(negedge clk);
    orr[MAIN] = 1'b0;
    nassert++;
    if (ir[MAIN] !== 1'b1 || ov[MAIN] !== 1'b0) begin
      nfail++; $display("FAIL hold_release got ir=%b ov=%b want ir=1 ov=0", ir[MAIN], ov[MAIN]);
    end
  endtask

  task automatic test_reset_mid;
    exp_t got, want; int unsigned lat; bit ok;
    start_op(16'h1234, 16'h0FED, 1'b1, 1'b0, ok);
    nassert++;
    if (!ok) begin
      nfail++; $display("FAIL reset_mid_accept got no accept want accept");
    end
    dq.delete();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    nassert++;
    if (ov[MAIN] !== 1'b0 || s[MAIN] !== '0 || ir[MAIN] !== 1'b1) begin
      nfail++;
      $display("FAIL reset_mid got ov=%b sum=%h ir=%b want ov=0 sum=0000 ir=1", ov[MAIN], s[MAIN], ir[MAIN]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    nassert++;
    if (ov[MAIN] !== 1'b0) begin
      nfail++; $display("FAIL reset_mid_no_result got ov=%b want 0", ov[MAIN]);
    end
    one_op(16'h1234, 16'h0FED, 1'b1, 1'b0, got, want, lat, ok);
    nassert++;
    if (!ok || got.sum !== 16'h2222 || got.cout !== 1'b0 || got.ovf !== 1'b0 || lat !== 4) begin
      nfail++;
      $display("FAIL reset_mid_recover ok=%b got sum=%h cout=%b ovf=%b lat=%0d want sum=2222 cout=0 ovf=0 lat=4",
               ok, got.sum, got.cout, got.ovf, lat);
    end
  endtask

  // Randomized back-to-back traffic on one instance with its own scoreboard.
  task automatic run_one(input int k, input int n);
    exp_t        q[$];
    int unsigned nd;
    int          got_n;
    nd    = W / dig_of(k);
    got_n = 0;
    fork
      begin : drv
        logic [W-1:0] x, y;
        logic         c, su;
        int           t;
        for (int i = 0; i < n; i++) begin
          @(negedge clk);
          if ($urandom_range(0, 7) == 0) begin
            iv[k] = 1'b0;
            @(negedge clk);
          end
          x = W'($urandom); y = W'($urandom);
          c = 1'($urandom_range(0, 1)); su = 1'($urandom_range(0, 1));
          a[k] = x; b[k] = y; cin[k] = c; sb[k] = su; iv[k] = 1'b1;
          t = 0;
          while (!ir[k] && t < 200) begin
            @(negedge clk);
            t++;
          end
          if (!ir[k]) begin
            nassert++; nfail++;
            $display("FAIL sweep_accept_timeout dig=%0d op=%0d got no accept want accept", dig_of(k), i);
            break;
          end
          q.push_back(model(x, y, c, su, cyc + 1));
        end
        @(negedge clk);
        iv[k] = 1'b0;
      end
      begin : mon
        exp_t e;
        bit   seen;
        int   wait_cyc;
        seen = 1'b0;
        wait_cyc = 0;
        while (got_n < n) begin
          @(negedge clk);
          orr[k] = 1'b0;
          if (ov[k]) begin
            if (!seen) begin
              seen = 1'b1;
              nassert++;
              if (q.size() == 0) begin
                nfail++; $display("FAIL sweep_spurious dig=%0d got out_valid want none", dig_of(k));
              end else if (cyc - q[0].acc != nd) begin
                nfail++; $display("FAIL sweep_latency dig=%0d got %0d want %0d", dig_of(k), cyc - q[0].acc, nd);
              end
            end
            if ($urandom_range(0, 3) != 0 && q.size() > 0) begin
              e = q.pop_front();
              nassert++;
              if (s[k] !== e.sum || co[k] !== e.cout || of[k] !== e.ovf) begin
                nfail++;
                $display("FAIL sweep_result dig=%0d op=%0d got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                         dig_of(k), got_n, s[k], co[k], of[k], e.sum, e.cout, e.ovf);
              end
              orr[k]   = 1'b1;
              seen     = 1'b0;
              got_n++;
              wait_cyc = 0;
            end
          end
          wait_cyc++;
          if (wait_cyc > 300) begin
            nassert++; nfail++;
            $display("FAIL sweep_result_timeout dig=%0d got %0d results want %0d", dig_of(k), got_n, n);
            break;
          end
        end
        @(negedge clk);
        orr[k] = 1'b0;
      end
    join
  endtask

  task automatic test_back_to_back;
    fork
      run_one(0, NOPS);
      run_one(1, NOPS);
      run_one(2, NOPS);
      run_one(3, NOPS);
    join
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      iv[k] = 1'b0; orr[k] = 1'b0; cin[k] = 1'b0; sb[k] = 1'b0;
      a[k] = '0; b[k] = '0;
    end
    test_reset();
    test_add_basic();
    test_add_edges();
    test_sub();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
